// File: rtl/obi_dma_master_pkg.sv
// rtl/obi_dma_master_pkg.sv - shared bus types and constants for the OBI word-copy DMA
package obi_dma_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      FIN
   } state_e;

   localparam int         BUS_ADDR_W = 17;
   localparam int         WORD_INC   = 4;
   localparam logic [3:0] BE_FULL    = 4'hF;

endpackage

// File: rtl/obi_dma_master.sv
// rtl/obi_dma_master.sv - OBI initiator that copies words as read-then-write pairs
module obi_dma_master
   import obi_dma_master_pkg::*;
#(
   parameter int ADDR_W = BUS_ADDR_W,
   parameter int LEN_W  = 13
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0] dst_addr_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              aborted_o,
   output logic [LEN_W-1:0]  remaining_o,
   output logic              data_req_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [31:0]       data_wdata_o,
   input  logic              data_gnt_i,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i
);

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_INC   = ADDR_W'(WORD_INC);

   state_e              state_q, state_n;
   logic [ADDR_W-1:0]   src_q, dst_q;
   logic [LEN_W-1:0]    rem_q;
   logic [31:0]         data_q;
   logic                abort_q;
   logic                req, we;
   logic [ADDR_W-1:0]   addr;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_n;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  src_q <= src_addr_i & ALIGN_MASK;
                  dst_q <= dst_addr_i & ALIGN_MASK;
                  rem_q <= len_i;
               end
            end
            RD_WAIT: begin
               if (data_rvalid_i) data_q <= data_rdata_i;
            end
            WR_WAIT: begin
               if (data_rvalid_i) begin
                  src_q <= src_q + ADDR_INC;
                  dst_q <= dst_q + ADDR_INC;
                  rem_q <= rem_q - LEN_W'(1);
               end
            end
            default: ;
         endcase
         // Abort is sticky for the whole transfer and only dropped as FIN hands back to IDLE.
         if (state_q == FIN)
            abort_q <= 1'b0;
         else if (state_q != IDLE && abort_i)
            abort_q <= 1'b1;
      end
   end

   always_comb begin
      state_n = state_q;
      req     = 1'b0;
      we      = 1'b0;
      addr    = '0;
      case (state_q)
         IDLE: begin
            if (start_i) state_n = (len_i == '0) ? FIN : RD_REQ;
         end
         RD_REQ: begin
            req  = 1'b1;
            addr = src_q;
            if (data_gnt_i) state_n = RD_WAIT;
         end
         RD_WAIT: begin
            if (data_rvalid_i) state_n = WR_REQ;
         end
         WR_REQ: begin
            req  = 1'b1;
            we   = 1'b1;
            addr = dst_q;
            if (data_gnt_i) state_n = WR_WAIT;
         end
         WR_WAIT: begin
            if (data_rvalid_i)
               state_n = (rem_q == LEN_W'(1) || abort_q || abort_i) ? FIN : RD_REQ;
         end
         FIN: begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == FIN);
   assign aborted_o    = (state_q == FIN) && abort_q;
   assign remaining_o  = rem_q;
   assign data_req_o   = req;
   assign data_we_o    = we;
   assign data_be_o    = BE_FULL;
   assign data_addr_o  = addr;
   assign data_wdata_o = data_q;

endmodule

// File: tb/tb_obi_dma_master.sv
// tb/tb_obi_dma_master.sv - randomized responder and copy model for obi_dma_master
module tb_obi_dma_master;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [16:0] src;
   logic [16:0] dst;
   logic [12:0] len;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [12:0] remaining;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [16:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;

   obi_dma_master #(.ADDR_W(17), .LEN_W(13)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
      .busy_o(busy), .done_o(done), .aborted_o(aborted), .remaining_o(remaining),
      .data_req_o(req), .data_we_o(we), .data_be_o(be), .data_addr_o(addr),
      .data_wdata_o(wdata), .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] memval(input logic [16:0] a);
      return ({15'd0, a} * 32'h9E3779B1) ^ 32'h5A5A_C3C3;
   endfunction

   // Responder: random grant stalls and rvalid latency, logs every granted transaction.
   int          smax = 0, lmax = 0, extra = 0;
   int          stall, lat_pick, resp_wait;
   bit          hs_prev, resp_pending, in_req;
   logic [16:0] h_addr;
   logic        h_we;
   logic [31:0] h_wdata, resp_data;
   logic [16:0] rd_log[$];
   logic [16:0] wr_log[$];
   logic [31:0] wd_log[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         gnt = 0; rvalid = 0; rdata = 0;
         hs_prev = 0; resp_pending = 0; in_req = 0;
      end else begin
         if (hs_prev) begin
            resp_pending = 1; resp_wait = lat_pick; hs_prev = 0;
         end
         rvalid = 0;
         rdata  = $urandom;
         if (resp_pending) begin
            if (resp_wait == 0) begin
               rvalid = 1; rdata = resp_data; resp_pending = 0;
            end else resp_wait--;
         end
         gnt = 0;
         if (req) begin
            if (!in_req) begin
               in_req = 1; h_addr = addr; h_we = we; h_wdata = wdata;
               stall = $urandom_range(0, smax);
               extra += stall;
            end else begin
               chk("stall_addr", addr, h_addr);
               chk("stall_we", we, h_we);
               chk("stall_wdata", wdata, h_wdata);
            end
            if (stall > 0) stall--;
            else begin
               gnt = 1; in_req = 0; hs_prev = 1;
               lat_pick = $urandom_range(0, lmax);
               extra += lat_pick;
               if (!we) begin
                  rd_log.push_back(addr);
                  resp_data = memval(addr);
               end else begin
                  wr_log.push_back(addr);
                  wd_log.push_back(wdata);
                  resp_data = $urandom;
               end
            end
         end
      end
   end

   task automatic run(input logic [16:0] s, input logic [16:0] d, input logic [12:0] n,
                      input int sm, input int lm, input int ab_cyc,
                      output int dcyc, output logic ab, output logic [12:0] rem,
                      output int bcyc, output int reqc);
      smax = sm; lmax = lm; extra = 0;
      rd_log.delete(); wr_log.delete(); wd_log.delete();
      dcyc = -1; ab = 1'bx; rem = 'x; bcyc = 0; reqc = 0;
      @(negedge clk);
      src = s; dst = d; len = n; start = 1; abort = (ab_cyc == 0);
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         start = 0;
         abort = (c == ab_cyc);
         #1;
         if (busy) bcyc++;
         if (req) reqc++;
         if (done) begin
            dcyc = c; ab = aborted; rem = remaining;
            break;
         end
      end
      @(negedge clk);
      abort = 0;
      #1;
      chk("busy_after_done", busy, 0);
   endtask

   task automatic verify(input logic [16:0] s, input logic [16:0] d, input int n);
      logic [16:0] sa, da, ea;
      sa = s & 17'h1FFFC;
      da = d & 17'h1FFFC;
      chk("n_reads", rd_log.size(), n);
      chk("n_writes", wr_log.size(), n);
      for (int i = 0; i < n && i < wr_log.size() && i < rd_log.size(); i++) begin
         ea = sa + 17'(4 * i);
         chk($sformatf("rd_addr[%0d]", i), rd_log[i], ea);
         chk($sformatf("wr_data[%0d]", i), wd_log[i], memval(ea));
         chk($sformatf("wr_addr[%0d]", i), wr_log[i], da + 17'(4 * i));
      end
   endtask

   int          dc, bc, rc;
   logic        ab;
   logic [12:0] rm;
   logic [16:0] rs, rd;
   int          rn;

   initial begin
      rst_n = 0; start = 0; abort = 0; src = 0; dst = 0; len = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_aborted", aborted, 0);
      chk("rst_remaining", remaining, 0);
      chk("rst_req", req, 0);
      chk("rst_we", we, 0);
      chk("rst_be", be, 4'hF);
      chk("rst_addr", addr, 0);
      chk("rst_wdata", wdata, 0);
      rst_n = 1;
      @(negedge clk);

      run(17'h0100, 17'h0200, 3, 0, 0, -1, dc, ab, rm, bc, rc);
      chk("nom_done_cycle", dc, 13);
      chk("nom_aborted", ab, 0);
      chk("nom_remaining", rm, 0);
      verify(17'h0100, 17'h0200, 3);

      run(17'h0040, 17'h0080, 0, 0, 0, -1, dc, ab, rm, bc, rc);
      chk("len0_done_cycle", dc, 1);
      chk("len0_req_cycles", rc, 0);
      chk("len0_busy_cycles", bc, 1);
      chk("len0_writes", wr_log.size(), 0);

      for (int k = 0; k < 5; k++) begin
         rs = 17'($urandom);
         rd = 17'($urandom);
         rn = $urandom_range(1, 6);
         run(rs, rd, 13'(rn), 5, 3, -1, dc, ab, rm, bc, rc);
         chk("rnd_done_cycle", dc, 4 * rn + 1 + extra);
         chk("rnd_aborted", ab, 0);
         chk("rnd_remaining", rm, 0);
         verify(rs, rd, rn);
      end

      run(17'h0300, 17'h0400, 5, 0, 0, 6, dc, ab, rm, bc, rc);
      chk("abort_done_cycle", dc, 9);
      chk("abort_aborted", ab, 1);
      chk("abort_remaining", rm, 3);
      verify(17'h0300, 17'h0400, 2);

      run(17'h0500, 17'h0600, 2, 0, 0, 0, dc, ab, rm, bc, rc);
      chk("idle_abort_done_cycle", dc, 9);
      chk("idle_abort_aborted", ab, 0);
      verify(17'h0500, 17'h0600, 2);

      run(17'h1FFFC, 17'h0203, 2, 0, 0, -1, dc, ab, rm, bc, rc);
      chk("wrap_done_cycle", dc, 9);
      if (rd_log.size() > 1) chk("wrap_rd1", rd_log[1], 17'h00000);
      if (wr_log.size() > 0) chk("wrap_wr0", wr_log[0], 17'h00200);
      verify(17'h1FFFC, 17'h0203, 2);

      smax = 0; lmax = 0;
      @(negedge clk);
      src = 17'h0700; dst = 17'h0800; len = 3; start = 1;
      repeat (3) @(negedge clk) start = 0;
      #1;
      chk("pre_rst_req", req, 1);
      chk("pre_rst_we", we, 1);
      rst_n = 0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_req", req, 0);
      chk("mid_rst_we", we, 0);
      chk("mid_rst_addr", addr, 0);
      chk("mid_rst_wdata", wdata, 0);
      chk("mid_rst_remaining", remaining, 0);
      chk("mid_rst_be", be, 4'hF);
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("mid_rst_no_done", done, 0);
      end
      rst_n = 1;
      run(17'h0700, 17'h0800, 3, 0, 0, -1, dc, ab, rm, bc, rc);
      chk("post_rst_done_cycle", dc, 13);
      chk("post_rst_aborted", ab, 0);
      verify(17'h0700, 17'h0800, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
